pipe_stage_skid: RTL

- Generic, parametrised pipeline stage register. It replaces hand-written per-stage registers such as ID/EX.
- Carries a data bundle and a control bundle between stages using a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so upstream and downstream timing are decoupled.
- Adds flush (bubble insertion), a forced bubble control value while empty, and a saturating stall counter for performance analysis.

---
 rtl/pipe_stage_skid.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready pipeline stage register with a
// two-entry skid buffer. The skid buffer lets in_ready come straight from
// a flop. The stage also supports flush (bubble insertion), drives a forced
// bubble control value while empty, and has a saturating stall counter.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is registered)
//   in_data/in_ctrl       upstream datapath / control bundles
//   flush                 discard all held entries
//   out_valid/out_ready   downstream handshake
//   out_data/out_ctrl     registered datapath / control bundles
//   clr_stats             clear stall_cnt
//   stall_cnt             saturating count of out_valid & ~out_ready cycles
module pipe_stage_skid #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int unsigned       STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  input  logic                   clr_stats,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  // Occupancy: EMPTY = no entry, ONE = main only, FULL = main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  entry_t in_entry;
  entry_t skid;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic to_bubble;

  assign in_entry.data = in_data;
  assign in_entry.ctrl = in_ctrl;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides any handshake.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state_next = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_next = FULL;
          else if (!in_fire && out_fire) state_next = EMPTY;
        end
        FULL:    if (out_fire) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Datapath load enables. During flush nothing is loaded, so an input
  // accepted in the same cycle is silently dropped.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY: load_main_in = in_fire;
        ONE: begin
          load_main_in = in_fire & out_fire;
          load_skid    = in_fire & ~out_fire;
        end
        FULL:    load_main_skid = out_fire;
        default: ;
      endcase
    end
    to_bubble = (state_next == EMPTY);
  end

  // Main/skid registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_ctrl  <= CTRL_BUBBLE;
      skid      <= '0;
    end else begin
      out_valid <= (state_next != EMPTY);
      in_ready  <= (state_next != FULL);
      if (load_main_in) begin
        out_data <= in_entry.data;
        out_ctrl <= in_entry.ctrl;
      end else if (load_main_skid) begin
        out_data <= skid.data;
        out_ctrl <= skid.ctrl;
      end else if (to_bubble) begin
        // out_data keeps its last value; only control is neutralised.
        out_ctrl <= CTRL_BUBBLE;
      end
      if (load_skid) begin
        skid <= in_entry;
      end
    end
  end

  // Saturating stall counter; flush does not clear it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule
